// File: rtl/sd_cmd_responder.sv
// rtl/sd_cmd_responder.sv - card-side SD CMD line command receiver and response transmitter
//
// Purpose:
//   Receives 48-bit host command frames on the SD CMD line, checks framing
//   and CRC7, hands good commands to local logic, then serialises the
//   48-bit response back onto CMD with its CRC7. Everything runs in the
//   clk_clk domain. sd_clk and CMD are oversampled, so clk_clk must run at
//   least 4x faster than sd_clk.
//
// Ports:
//   clk_clk      system clock
//   reset_reset  asynchronous active-high reset
//   sd_clk       host SD clock (asynchronous, synchronised here)
//   sd_cmd_in    CMD pad input (asynchronous, synchronised here)
//   sd_cmd_out   CMD value driven while sd_cmd_oe=1
//   sd_cmd_oe    CMD pad tristate enable
//   cmd_valid    one-cycle pulse: good command received
//   cmd_index    last good command index (held)
//   cmd_arg      last good command argument (held)
//   cmd_crc_err  one-cycle pulse: frame rejected
//   cmd_timeout  one-cycle pulse: no response within NCR_MAX edges
//   rsp_valid    response offered by local logic
//   rsp_ready    response accepted (only while waiting for one)
//   rsp_index    response index field
//   rsp_arg      response payload

module sd_cmd_responder #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        sd_clk,
  input  logic        sd_cmd_in,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        cmd_crc_err,
  output logic        cmd_timeout,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [5:0]  rsp_index,
  input  logic [31:0] rsp_arg
);

  localparam int NCR_W = $clog2(NCR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_CHECK,
    S_WAIT_RSP,
    S_TX
  } state_t;

  state_t state, state_nxt;

  // Bits [1:0] form the synchroniser; bit [2] is the previous synchronised
  // value used for edge detection.
  logic [2:0]  sd_clk_sync;
  logic [1:0]  sd_cmd_sync;
  logic        sd_rise;
  logic        sd_fall;
  logic        cmd_bit;

  logic [47:0] rx_shift;
  logic [5:0]  rx_cnt;
  logic [NCR_W-1:0] ncr_cnt;
  logic        rsp_have;
  logic [47:0] tx_shift;
  logic [5:0]  tx_left;

  logic [6:0]  rx_crc_calc;
  logic        frame_good;
  logic        handshake;
  logic        ncr_expire;
  logic        tx_start;
  logic        timeout_hit;
  logic [39:0] rsp_body;
  logic [47:0] rsp_frame;

  // Serial CRC7 (x^7 + x^3 + 1, initial value 0) over 40 message bits, MSB first.
  function automatic logic [6:0] crc7_40(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = crc[6] ^ data[i];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sd_clk_sync <= 3'b000;
      sd_cmd_sync <= 2'b11;
    end else begin
      sd_clk_sync <= {sd_clk_sync[1:0], sd_clk};
      sd_cmd_sync <= {sd_cmd_sync[0], sd_cmd_in};
    end
  end

  assign sd_rise = sd_clk_sync[1] & ~sd_clk_sync[2];
  assign sd_fall = ~sd_clk_sync[1] & sd_clk_sync[2];
  assign cmd_bit = sd_cmd_sync[1];

  // Frame layout in rx_shift: [47] start, [46] transmission, [45:40] index,
  // [39:8] argument, [7:1] CRC7, [0] end.
  assign rx_crc_calc = crc7_40(rx_shift[47:8]);
  assign frame_good  = ~rx_shift[47] & rx_shift[46] & rx_shift[0] &
                       (rx_crc_calc == rx_shift[7:1]);

  assign rsp_body  = {2'b00, rsp_index, rsp_arg};
  assign rsp_frame = {rsp_body, crc7_40(rsp_body), 1'b1};

  assign handshake  = rsp_valid & rsp_ready;
  assign ncr_expire = sd_rise & (ncr_cnt == NCR_W'(NCR_MAX - 1));
  assign tx_start   = sd_fall & rsp_have & (ncr_cnt >= NCR_W'(NCR_MIN));

  always_comb begin
    state_nxt   = state;
    rsp_ready   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (sd_rise && !cmd_bit) state_nxt = S_RX;
      end
      S_RX: begin
        if (sd_rise && rx_cnt == 6'd47) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        state_nxt = frame_good ? S_WAIT_RSP : S_IDLE;
      end
      S_WAIT_RSP: begin
        // Ready drops once a response is latched so it is taken only once.
        rsp_ready = ~rsp_have;
        if (tx_start) begin
          state_nxt = S_TX;
        end else if (ncr_expire && !rsp_have && !rsp_valid) begin
          // A handshake in the expiry cycle wins over the timeout.
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_TX: begin
        if (sd_fall && tx_left == 6'd0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state       <= S_IDLE;
      rx_shift    <= '0;
      rx_cnt      <= 6'd0;
      ncr_cnt     <= '0;
      rsp_have    <= 1'b0;
      tx_shift    <= '1;
      tx_left     <= 6'd0;
      sd_cmd_out  <= 1'b1;
      sd_cmd_oe   <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_crc_err <= 1'b0;
      cmd_timeout <= 1'b0;
      cmd_index   <= 6'd0;
      cmd_arg     <= 32'd0;
    end else begin
      state       <= state_nxt;
      cmd_valid   <= 1'b0;
      cmd_crc_err <= 1'b0;
      cmd_timeout <= timeout_hit;
      case (state)
        S_IDLE: begin
          if (sd_rise && !cmd_bit) begin
            rx_shift <= 48'd0;   // start bit already captured as bit 0
            rx_cnt   <= 6'd1;
          end
        end
        S_RX: begin
          if (sd_rise) begin
            rx_shift <= {rx_shift[46:0], cmd_bit};
            rx_cnt   <= rx_cnt + 6'd1;
          end
        end
        S_CHECK: begin
          ncr_cnt  <= '0;
          rsp_have <= 1'b0;
          if (frame_good) begin
            cmd_valid <= 1'b1;
            cmd_index <= rx_shift[45:40];
            cmd_arg   <= rx_shift[39:8];
          end else begin
            cmd_crc_err <= 1'b1;
          end
        end
        S_WAIT_RSP: begin
          if (sd_rise && ncr_cnt != NCR_W'(NCR_MAX)) ncr_cnt <= ncr_cnt + NCR_W'(1);
          if (handshake) begin
            rsp_have <= 1'b1;
            tx_shift <= rsp_frame;
          end
          if (tx_start) begin
            sd_cmd_oe  <= 1'b1;
            sd_cmd_out <= tx_shift[47];
            tx_shift   <= {tx_shift[46:0], 1'b1};
            tx_left    <= 6'd47;
          end
        end
        S_TX: begin
          if (sd_fall) begin
            if (tx_left == 6'd0) begin
              sd_cmd_oe  <= 1'b0;
              sd_cmd_out <= 1'b1;
            end else begin
              sd_cmd_out <= tx_shift[47];
              tx_shift   <= {tx_shift[46:0], 1'b1};
              tx_left    <= tx_left - 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb/tb_sd_cmd_responder.sv - randomized self-checking bench for sd_cmd_responder
module tb_sd_cmd_responder;

  localparam int NCR_MIN = 2;
  localparam int NCR_MAX = 64;
  localparam int HALF    = 40;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        sd_clk;
  logic        sd_cmd_in;
  logic        sd_cmd_out;
  logic        sd_cmd_oe;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_crc_err;
  logic        cmd_timeout;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_index;
  logic [31:0] rsp_arg;

  sd_cmd_responder #(.NCR_MIN(NCR_MIN), .NCR_MAX(NCR_MAX)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .sd_clk      (sd_clk),
    .sd_cmd_in   (sd_cmd_in),
    .sd_cmd_out  (sd_cmd_out),
    .sd_cmd_oe   (sd_cmd_oe),
    .cmd_valid   (cmd_valid),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .cmd_crc_err (cmd_crc_err),
    .cmd_timeout (cmd_timeout),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_index   (rsp_index),
    .rsp_arg     (rsp_arg)
  );

  always #5 clk_clk = ~clk_clk;

  int errors = 0;
  int checks = 0;

  int n_valid   = 0;
  int n_crc_err = 0;
  int n_timeout = 0;
  int n_oe_hi   = 0;

  logic        host_oe;
  logic        host_cmd;
  logic [5:0]  exp_index;
  logic [31:0] exp_arg;

  always @(negedge clk_clk) begin
    if (cmd_valid)   n_valid   <= n_valid + 1;
    if (cmd_crc_err) n_crc_err <= n_crc_err + 1;
    if (cmd_timeout) n_timeout <= n_timeout + 1;
    if (sd_cmd_oe)   n_oe_hi   <= n_oe_hi + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC7 by polynomial long division of msg * x^7 by x^7 + x^3 + 1.
  function automatic logic [6:0] model_crc7(input logic [39:0] msg);
    logic [46:0] rem;
    rem = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    return rem[6:0];
  endfunction

  function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, model_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] make_rsp(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b00, idx, arg, model_crc7({2'b00, idx, arg}), 1'b1};
  endfunction

  // One host clock period: data set while sd_clk low, sampled at the rise.
  task automatic sd_cycle(input logic b);
    sd_cmd_in = b;
    #HALF;
    sd_clk   = 1'b1;
    host_oe  = sd_cmd_oe;
    host_cmd = sd_cmd_out;
    #HALF;
    sd_clk = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sd_cycle(1'b1);
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) sd_cycle(f[i]);
  endtask

  // Clocks the host after a command end bit and collects driven response bits.
  // rsp_valid rises after raise_at host periods; start_edge is the first
  // host rising edge (1-based after the end bit) that sees oe=1.
  task automatic run_response(input int raise_at, input logic noisy, input int stop_after,
                              output int start_edge, output logic [47:0] got,
                              output logic oe_after);
    int   e;
    int   nbits;
    logic b;
    start_edge = -1;
    got        = '0;
    nbits      = 0;
    e          = 0;
    oe_after   = 1'b0;
    if (raise_at == 0) rsp_valid = 1'b1;
    while (nbits < stop_after && e < 120) begin
      b = (noisy && nbits >= 4 && nbits < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      sd_cycle(b);
      e++;
      if (host_oe) begin
        if (start_edge < 0) start_edge = e;
        got = {got[46:0], host_cmd};
        nbits++;
      end
      if (e == raise_at) rsp_valid = 1'b1;
    end
    if (stop_after == 48) begin
      sd_cycle(1'b1);
      oe_after  = host_oe;
      rsp_valid = 1'b0;
    end
  endtask

  task automatic good_txn(input string tag, input logic [47:0] f, input logic [5:0] ri,
                          input logic [31:0] ra, input int raise_at, input logic noisy,
                          input logic pre);
    int          v0, c0, se, exp_se;
    logic [47:0] got;
    logic        oa;
    rsp_index = ri;
    rsp_arg   = ra;
    if (pre) rsp_valid = 1'b1;
    v0 = n_valid;
    c0 = n_crc_err;
    send_frame(f);
    exp_index = f[45:40];
    exp_arg   = f[39:8];
    check({tag, "_valid"}, n_valid - v0, 1);
    check({tag, "_index"}, cmd_index, exp_index);
    check({tag, "_arg"}, cmd_arg, exp_arg);
    if (!pre) check({tag, "_ready"}, rsp_ready, 1'b1);
    v0 = n_valid;
    run_response(raise_at, noisy, 48, se, got, oa);
    exp_se = ((raise_at > NCR_MIN) ? raise_at : NCR_MIN) + 1;
    check({tag, "_start_edge"}, se, exp_se);
    check({tag, "_rsp_frame"}, got, make_rsp(ri, ra));
    check({tag, "_oe_after"}, oa, 1'b0);
    check({tag, "_no_extra_valid"}, n_valid - v0, 0);
    check({tag, "_no_crc_err"}, n_crc_err - c0, 0);
  endtask

  task automatic bad_txn(input string tag, input logic [47:0] f, input logic pre);
    int v0, c0, o0;
    rsp_index = 6'($urandom);
    rsp_arg   = $urandom;
    if (pre) rsp_valid = 1'b1;
    v0 = n_valid;
    c0 = n_crc_err;
    o0 = n_oe_hi;
    send_frame(f);
    idle(3);
    check({tag, "_crc_err"}, n_crc_err - c0, 1);
    check({tag, "_no_valid"}, n_valid - v0, 0);
    check({tag, "_index_kept"}, cmd_index, exp_index);
    check({tag, "_arg_kept"}, cmd_arg, exp_arg);
    check({tag, "_no_oe"}, n_oe_hi - o0, 0);
    rsp_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f;
    logic [47:0] got;
    logic [5:0]  ci, ri;
    logic [31:0] ca, ra;
    logic        oa, pre, corrupt, noisy;
    int          se, v0, c0, t0, o0, ra_at, flip;

    reset_reset = 1'b1;
    sd_clk      = 1'b0;
    sd_cmd_in   = 1'b1;
    rsp_valid   = 1'b0;
    rsp_index   = 6'd0;
    rsp_arg     = 32'd0;
    exp_index   = 6'd0;
    exp_arg     = 32'd0;
    #52;
    check("rst_oe", sd_cmd_oe, 1'b0);
    check("rst_out", sd_cmd_out, 1'b1);
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_index", cmd_index, 6'd0);
    check("rst_arg", cmd_arg, 32'd0);
    check("rst_crc_err", cmd_crc_err, 1'b0);
    check("rst_timeout", cmd_timeout, 1'b0);
    check("rst_ready", rsp_ready, 1'b0);
    #70;
    reset_reset = 1'b0;
    idle(4);

    good_txn("cmd0", 48'h40_0000_0000_95, 6'($urandom), $urandom, 0, 1'b0, 1'b0);
    idle(2);

    good_txn("cmd8", 48'h48_0000_01AA_87, 6'd8, 32'h0000_01AA, 0, 1'b0, 1'b0);
    idle(2);

    bad_txn("cmd17", 48'h51_0000_0000_57, 1'b0);

    f  = make_cmd(6'd55, $urandom);
    v0 = n_valid;
    t0 = n_timeout;
    o0 = n_oe_hi;
    send_frame(f);
    exp_index = f[45:40];
    exp_arg   = f[39:8];
    check("to_valid", n_valid - v0, 1);
    check("to_ready", rsp_ready, 1'b1);
    se = -1;
    for (int e = 1; e <= NCR_MAX + 4; e++) begin
      sd_cycle(1'b1);
      if (se < 0 && n_timeout != t0) se = e;
    end
    check("to_edge", se, NCR_MAX);
    check("to_pulses", n_timeout - t0, 1);
    check("to_ready_after", rsp_ready, 1'b0);
    check("to_no_oe", n_oe_hi - o0, 0);
    good_txn("to_cmd0", 48'h40_0000_0000_95, 6'($urandom), $urandom, 0, 1'b0, 1'b0);
    idle(2);

    ri = 6'($urandom);
    ra = $urandom;
    rsp_index = ri;
    rsp_arg   = ra;
    send_frame(make_cmd(6'd13, $urandom));
    run_response(0, 1'b0, 21, se, got, oa);
    check("rst_mid_bits", got[20:0], make_rsp(ri, ra) >> 27);
    check("rst_mid_oe_before", sd_cmd_oe, 1'b1);
    v0 = n_valid;
    c0 = n_crc_err;
    t0 = n_timeout;
    reset_reset = 1'b1;
    #1;
    check("rst_mid_oe", sd_cmd_oe, 1'b0);
    check("rst_mid_out", sd_cmd_out, 1'b1);
    check("rst_mid_ready", rsp_ready, 1'b0);
    check("rst_mid_index", cmd_index, 6'd0);
    check("rst_mid_arg", cmd_arg, 32'd0);
    exp_index = 6'd0;
    exp_arg   = 32'd0;
    #(HALF - 1);
    rsp_valid = 1'b0;
    idle(2);
    reset_reset = 1'b0;
    idle(3);
    check("rst_mid_no_valid", n_valid - v0, 0);
    check("rst_mid_no_crc", n_crc_err - c0, 0);
    check("rst_mid_no_to", n_timeout - t0, 0);
    good_txn("rst_cmd0", 48'h40_0000_0000_95, 6'($urandom), $urandom, 0, 1'b0, 1'b0);
    idle(2);

    good_txn("early_noisy", make_cmd(6'd17, $urandom), 6'($urandom), $urandom, 1, 1'b1, 1'b0);
    idle(1);
    good_txn("late", make_cmd(6'd55, $urandom), 6'($urandom), $urandom, 5, 1'b0, 1'b0);
    idle(1);
    good_txn("pre", make_cmd(6'd2, $urandom), 6'($urandom), $urandom, 0, 1'b1, 1'b1);
    idle(1);

    for (int i = 0; i < 16; i++) begin
      ci      = 6'($urandom);
      ca      = $urandom;
      ri      = 6'($urandom);
      ra      = $urandom;
      f       = make_cmd(ci, ca);
      corrupt = ($urandom_range(0, 3) == 0);
      pre     = ($urandom_range(0, 3) == 0);
      noisy   = 1'($urandom_range(0, 1));
      ra_at   = pre ? 0 : int'($urandom_range(0, 6));
      if (corrupt) begin
        flip    = int'($urandom_range(0, 46));
        f[flip] = ~f[flip];
        bad_txn("rnd_bad", f, pre);
      end else begin
        good_txn("rnd", f, ri, ra, ra_at, noisy, pre);
      end
      idle(int'($urandom_range(1, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
